clk_period_meter: RTL and testbench
===================================

// Module: clk_period_meter
// PURPOSE
//   Measures an asynchronous slow clock (e.g. an on-board divided clock or an
//   external test clock) against the system clock. Reports its period in
//   system-clock cycles, the inverse of the divider function. Used for
//   self-check of divided clocks and for frequency display logic.
// PARAMETERS
//   CNT_W        32           width of period/high_time counters
//   TIMEOUT      200_000_000  cycles without an edge before timeout (2 s @ 100 MHz); 2 <= TIMEOUT <= 2^CNT_W-1
//   SYNC_STAGES  2            synchroniser depth for clk_in (>= 2)
// PORTS
//   clk           in   1      system clock
//   rst_n         in   1      asynchronous active-low reset
//   clk_in        in   1      clock under test, asynchronous to clk
//   enable        in   1      1 = measure; 0 = return to IDLE
//   period        out  CNT_W  last measured period, clk cycles
//   high_time     out  CNT_W  last measured high time, clk cycles (see CONFIGURATION)
//   period_valid  out  1      one-cycle pulse when period/high_time update
//   locked        out  1      1 after first valid period; 0 in IDLE/TIMEOUT
//   timeout       out  1      level; 1 while in TIMEOUT state
// BEHAVIOUR
//   - Reset: state IDLE, sync chain 0, all counters 0, every output 0. Reset is async:
//     outputs clear immediately, not on the next clk edge.
//   - clk_in passes a SYNC_STAGES flop chain -> s; rise = s & ~s_d (1 cycle).
//     Fixed latency SYNC_STAGES+1 from clk_in edge to rise; it cancels out of period.
//   - cnt counts clk cycles. period = cycles between consecutive rise pulses;
//     a clk_in with period P clk cycles yields period == P.
//   - FSM:
//     IDLE: cnt=0; enable=1 -> WAIT_FIRST.
//     WAIT_FIRST: cnt++; rise -> MEASURE, cnt<=1 (no valid pulse);
//       cnt==TIMEOUT-1 -> TIMEOUT.
//     MEASURE: cnt++; on rise: period<=cnt, period_valid=1 for 1 cycle,
//       locked<=1, cnt<=1. cnt==TIMEOUT-1 with no rise -> TIMEOUT.
//     TIMEOUT: timeout=1, locked=0, period/high_time retained; cnt held;
//       rise -> MEASURE, cnt<=1, timeout<=0 (no valid pulse).
//   - enable=0 in any state: next cycle IDLE, cnt=0, locked=0, timeout=0;
//     period/high_time retained. Re-enable needs two rises before the next valid.
//   - Simultaneous rise and cnt==TIMEOUT-1 in MEASURE: rise wins, period=cnt.
//   - cnt never wraps (bounded by TIMEOUT). timeout asserts TIMEOUT cycles
//     after the last rise.
//   - clk_in high and low phases must each be >= SYNC_STAGES+1 clk cycles;
//     shorter pulses may be missed (not an error condition).
// CONFIGURATION
//   PERIOD_METER_DUTY_EN defined: hcnt counts cycles with s==1 from a rise
//     cycle (inclusive) to the next rise (exclusive). On rise: high_time<=hcnt,
//     hcnt<=1. Updates together with period under the same period_valid.
//   Not defined: high_time port present, tied to 0; no hcnt logic.
// TESTING
//   1 rst_n=0 for 5 cycles, clk_in toggling, enable=1 -> all outputs 0, no period_valid.
//   2 enable=1, clk_in high 3/low 5 repeating -> first valid on 2nd rise; period=8 on
//     every valid; locked=1 from first valid; with DUTY_EN high_time=3, else 0.
//   3 TIMEOUT=100, stop clk_in low after locked -> timeout=1, locked=0 exactly 100
//     cycles after last rise; period stays 8; restart period 8 -> timeout=0 on
//     first rise, next valid period=8.
//   4 enable=0 mid-MEASURE -> IDLE next cycle, locked=0, period=8 kept; enable=1
//     -> no valid until 2nd rise, then period=8.
//   5 rst_n falls between clk edges mid-MEASURE -> outputs 0 immediately; after
//     release, behaves as fresh start (test 2 sequence).
//   6 clk_in period changes 8 -> 20 on an edge -> valid sequence 8,8,20,20.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures the period (and optionally the high time) of an asynchronous slow clock in clk cycles.
// Optional duty measurement is enabled by defining PERIOD_METER_DUTY_EN.
module clk_period_meter #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 200_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_FIRST,
        ST_MEASURE,
        ST_TIMEOUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   s_d_reg;
    logic                   s;
    logic                   rise;

    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             valid_reg,  valid_next;
    logic             locked_reg, locked_next;

    // Synchroniser chain plus one extra flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            s_d_reg  <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], clk_in};
            s_d_reg  <= s;
        end
    end

    assign s    = sync_reg[SYNC_STAGES-1];
    assign rise = s & ~s_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            period_reg <= '0;
            valid_reg  <= 1'b0;
            locked_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            period_reg <= period_next;
            valid_reg  <= valid_next;
            locked_reg <= locked_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        period_next = period_reg;
        valid_next  = 1'b0;
        locked_next = locked_reg;
        if (!enable) begin
            state_next  = ST_IDLE;
            cnt_next    = '0;
            locked_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_WAIT_FIRST;
                    cnt_next   = '0;
                end
                ST_WAIT_FIRST: begin
                    if (rise) begin
                        state_next = ST_MEASURE;
                        cnt_next   = CNT_ONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next  = ST_TIMEOUT;
                        locked_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    // A rise on the last count still yields a valid period
                    if (rise) begin
                        period_next = cnt_reg;
                        valid_next  = 1'b1;
                        locked_next = 1'b1;
                        cnt_next    = CNT_ONE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next  = ST_TIMEOUT;
                        locked_next = 1'b0;
                    end else begin
                        cnt_next = cnt_reg + CNT_ONE;
                    end
                end
                ST_TIMEOUT: begin
                    locked_next = 1'b0;
                    if (rise) begin
                        state_next = ST_MEASURE;
                        cnt_next   = CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

`ifdef PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] high_reg, high_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_reg <= '0;
            high_reg <= '0;
        end else begin
            hcnt_reg <= hcnt_next;
            high_reg <= high_next;
        end
    end

    // hcnt restarts at 1 on every rise, so it counts the rise cycle itself
    always_comb begin
        hcnt_next = hcnt_reg;
        high_next = high_reg;
        if (!enable) begin
            hcnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: hcnt_next = '0;
                ST_WAIT_FIRST, ST_TIMEOUT: begin
                    if (rise) hcnt_next = CNT_ONE;
                end
                ST_MEASURE: begin
                    if (rise) begin
                        high_next = hcnt_reg;
                        hcnt_next = CNT_ONE;
                    end else begin
                        hcnt_next = hcnt_reg + CNT_W'(s);
                    end
                end
                default: hcnt_next = '0;
            endcase
        end
    end

    assign high_time = high_reg;
`else
    assign high_time = '0;
`endif

    assign period       = period_reg;
    assign period_valid = valid_reg;
    assign locked       = locked_reg;
    assign timeout      = (state_reg == ST_TIMEOUT);

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomised bench for clk_period_meter: an event-level model (rise times, counts since enable)
// predicts every output each cycle; directed phases pin the model with literal values.
module tb_clk_period_meter;

    localparam int CNT_W = 16;
    localparam int TO    = 100;
    localparam int SS    = 2;
`ifdef PERIOD_METER_DUTY_EN
    localparam bit HIGH_ON = 1'b1;
`else
    localparam bit HIGH_ON = 1'b0;
`endif

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             clk_in = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             timeout;

    int total = 0;
    int bad   = 0;

    clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_in       (clk_in),
        .enable       (enable),
        .period       (period),
        .high_time    (high_time),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit xh [0:65535];          // clk_in as captured at each clk edge (0 while in reset)
    int cyc = 10;
    bit m_active, m_to, m_locked, m_valid;
    int m_rises, m_last, m_wstart, m_period, m_high;

    function automatic int high_count(int a, int b);
        int c = 0;
        for (int k = a; k < b; k++) c += int'(xh[k]);
        return c;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_active = 0; m_to = 0; m_locked = 0; m_valid = 0;
                m_rises = 0; m_period = 0; m_high = 0;
                for (int k = 0; k <= SS + 1; k++) xh[cyc-k] = 1'b0;
            end else begin
                bit rise;
                cyc = cyc + 1;
                xh[cyc] = clk_in;
                rise = xh[cyc-SS] && !xh[cyc-SS-1];
                m_valid = 0;
                if (!enable) begin
                    m_active = 0; m_locked = 0; m_to = 0;
                end else if (!m_active) begin
                    m_active = 1; m_wstart = cyc; m_rises = 0;
                end else if (rise) begin
                    if (m_rises > 0 && !m_to) begin
                        m_valid  = 1;
                        m_period = cyc - m_last;
                        m_high   = high_count(m_last - SS, cyc - SS);
                        m_locked = 1;
                    end
                    m_to = 0;
                    m_rises++;
                    m_last = cyc;
                end else if (!m_to && ((m_rises == 0 && cyc - m_wstart == TO) ||
                                       (m_rises > 0 && cyc - m_last == TO - 1))) begin
                    m_to = 1;
                    m_locked = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    int vq[$];
    int last_valid_cyc = 0;
    int to_cyc = 0;
    bit prev_to = 0;

    initial begin
        forever begin
            @(negedge clk);
            chk("period",       int'(period),       m_period);
            chk("high_time",    int'(high_time),    HIGH_ON ? m_high : 0);
            chk("period_valid", int'(period_valid), int'(m_valid));
            chk("locked",       int'(locked),       int'(m_locked));
            chk("timeout",      int'(timeout),      int'(m_to));
            if (period_valid) begin
                vq.push_back(int'(period));
                last_valid_cyc = cyc;
                $display("valid cyc=%0d period=%0d high_time=%0d", cyc, period, high_time);
            end
            if (timeout && !prev_to) to_cyc = cyc;
            prev_to = timeout;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wave(int h, int l, int n);
        repeat (n) begin
            clk_in = 1'b1;
            tick(h);
            clk_in = 1'b0;
            tick(l);
        end
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_period"}, int'(period), 0);
        chk({tag, "_high"},   int'(high_time), 0);
        chk({tag, "_valid"},  int'(period_valid), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_to"},     int'(timeout), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // reset with clk_in toggling and enable high
        rst_n = 1'b0;
        enable = 1'b1;
        tick(1);
        repeat (5) begin
            clk_in = ~clk_in;
            tick(1);
        end
        chk_zero("t1");
        clk_in = 1'b0;
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);

        // 3 high / 5 low: 6 rises give 5 valids of period 8
        base = vq.size();
        wave(3, 5, 6);
        chk("t2_nvalid", vq.size() - base, 5);
        chk("t2_period", int'(period), 8);
        chk("t2_locked", int'(locked), 1);
        chk("t2_high",   int'(high_time), HIGH_ON ? 3 : 0);

        // stop clk_in low: timeout exactly TO cycles after the last rise pulse
        tick(120);
        chk("t3_timeout", int'(timeout), 1);
        chk("t3_locked",  int'(locked), 0);
        chk("t3_period",  int'(period), 8);
        chk("t3_delay",   to_cyc - (last_valid_cyc - 1), TO);
        base = vq.size();
        wave(3, 5, 3);
        chk("t3_nvalid",  vq.size() - base, 2);
        chk("t3_to_clr",  int'(timeout), 0);
        chk("t3_period2", int'(period), 8);

        // enable low mid-measure, then re-enable
        wave(3, 5, 2);
        enable = 1'b0;
        tick(3);
        chk("t4_locked", int'(locked), 0);
        chk("t4_period", int'(period), 8);
        enable = 1'b1;
        base = vq.size();
        wave(3, 5, 4);
        chk("t4_nvalid", vq.size() - base, 3);
        chk("t4_period2", int'(period), 8);

        // asynchronous reset between clock edges while clk_in is high
        wave(3, 5, 2);
        clk_in = 1'b1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t5");
        tick(5);
        clk_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        base = vq.size();
        wave(3, 5, 6);
        chk("t5_nvalid", vq.size() - base, 5);
        chk("t5_period", int'(period), 8);

        // period change 8 -> 20 on an edge
        wave(3, 5, 4);
        wave(10, 10, 3);
        chk("t6_seq0", vq[vq.size()-4], 8);
        chk("t6_seq1", vq[vq.size()-3], 8);
        chk("t6_seq2", vq[vq.size()-2], 20);
        chk("t6_seq3", vq[vq.size()-1], 20);

        // boundary: period TO-1 is still measured, period TO times out first
        wave(40, 59, 3);
        chk("bnd_period99", int'(period), 99);
        chk("bnd_locked99", int'(locked), 1);
        base = vq.size();
        wave(40, 60, 3);
        chk("bnd_nvalid100", vq.size() - base, 1);
        chk("bnd_locked100", int'(locked), 0);

        // randomised phase
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                enable = 1'b0;
                tick(int'($urandom_range(1, 4)));
                enable = 1'b1;
            end else if (r == 1) begin
                clk_in = 1'b0;
                tick(int'($urandom_range(95, 110)));
            end
            wave(int'($urandom_range(2, 12)), int'($urandom_range(2, 12)),
                 int'($urandom_range(1, 4)));
        end
        tick(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
